// File: rtl/conversor_tempo_bcd_pkg.sv
// Shared types and constants for the elapsed-time to BCD converter and its
// 7-segment display scanner.
package conversor_tempo_pkg;

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        DESLOCANDO = 2'd1,
        CONCLUIDO  = 2'd2
    } estado_t;

    // One shift per bit of the 12-bit binary input
    localparam int N_ITER = 12;

    // Segment codes, {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_APAGA = 7'b1111111;

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift
    function automatic logic [15:0] ajusta_bcd(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int k = 0; k < 4; k++) begin
            if (v[4*k +: 4] >= 4'd5)
                r[4*k +: 4] = v[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/conversor_tempo_bcd_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking.
module decodificador_7seg
    import conversor_tempo_pkg::*;
(
    input  logic [3:0] i_digito,
    input  logic       i_apaga,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_APAGA;
        if (!i_apaga) begin
            case (i_digito)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_APAGA;
            endcase
        end
    end

endmodule

// File: rtl/conversor_tempo_bcd.sv
// Converts a 12-bit millisecond count to 4 BCD digits (sequential double-dabble)
// and drives a multiplexed, leading-zero-blanked 4-digit 7-segment display.
module conversor_tempo_bcd
    import conversor_tempo_pkg::*;
#(
    parameter int DIV_VARREDURA = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] tempo,
    output logic [15:0] bcd,
    output logic        pronto,
    output logic        ocupado,
    output logic [3:0]  anodo,
    output logic [6:0]  seg
);

    localparam int CW = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;

    estado_t       r_estado, w_prox;
    logic          w_carrega, w_desloca, w_conclui, w_ocupado;
    logic [11:0]   r_ultimo;
    logic [11:0]   r_bin;
    logic [15:0]   r_bcd_work;
    logic [3:0]    r_iter;
    logic [15:0]   r_bcd;
    logic          r_pronto;
    logic [15:0]   w_ajustado;
    logic [27:0]   w_deslocado;
    logic [CW-1:0] r_scan;
    logic [1:0]    r_digito;
    logic [3:0]    w_nibble;
    logic          w_apaga;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_estado <= OCIOSO;
        else        r_estado <= w_prox;
    end

    // tempo is only looked at in OCIOSO, so mid-conversion changes wait
    // for the next comparison against r_ultimo
    always_comb begin
        w_prox    = r_estado;
        w_carrega = 1'b0;
        w_desloca = 1'b0;
        w_conclui = 1'b0;
        w_ocupado = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (tempo != r_ultimo) begin
                    w_carrega = 1'b1;
                    w_prox    = DESLOCANDO;
                end
            end
            DESLOCANDO: begin
                w_desloca = 1'b1;
                w_ocupado = 1'b1;
                if (r_iter == 4'(N_ITER - 1)) w_prox = CONCLUIDO;
            end
            CONCLUIDO: begin
                w_conclui = 1'b1;
                w_ocupado = 1'b1;
                w_prox    = OCIOSO;
            end
            default: w_prox = OCIOSO;
        endcase
    end

    assign w_ajustado  = ajusta_bcd(r_bcd_work);
    assign w_deslocado = {w_ajustado[14:0], r_bin, 1'b0};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ultimo   <= '0;
            r_bin      <= '0;
            r_bcd_work <= '0;
            r_iter     <= '0;
            r_bcd      <= '0;
            r_pronto   <= 1'b0;
        end else begin
            r_pronto <= w_conclui;
            if (w_carrega) begin
                r_bin      <= tempo;
                r_ultimo   <= tempo;
                r_bcd_work <= '0;
                r_iter     <= '0;
            end else if (w_desloca) begin
                {r_bcd_work, r_bin} <= w_deslocado;
                r_iter              <= r_iter + 4'd1;
            end
            if (w_conclui) r_bcd <= r_bcd_work;
        end
    end

    // Display scan runs freely; it never restarts on a new result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_scan   <= '0;
            r_digito <= '0;
        end else if (r_scan == CW'(DIV_VARREDURA - 1)) begin
            r_scan   <= '0;
            r_digito <= r_digito + 2'd1;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    always_comb begin
        w_nibble = r_bcd[3:0];
        w_apaga  = 1'b0;
        case (r_digito)
            2'd0: begin w_nibble = r_bcd[3:0];   w_apaga = 1'b0;                 end
            2'd1: begin w_nibble = r_bcd[7:4];   w_apaga = (r_bcd[15:4] == '0);  end
            2'd2: begin w_nibble = r_bcd[11:8];  w_apaga = (r_bcd[15:8] == '0);  end
            default: begin w_nibble = r_bcd[15:12]; w_apaga = (r_bcd[15:12] == '0); end
        endcase
    end

    decodificador_7seg u_dec (
        .i_digito (w_nibble),
        .i_apaga  (w_apaga),
        .o_seg    (seg)
    );

    assign anodo   = ~(4'b0001 << r_digito);
    assign bcd     = r_bcd;
    assign pronto  = r_pronto;
    assign ocupado = w_ocupado;

endmodule

// File: tb/tb_conversor_tempo_bcd.sv
// Directed bench for conversor_tempo_bcd with a fast display scan.
module tb_conversor_tempo_bcd;

    logic        clock;
    logic        reset;
    logic [11:0] tempo;
    logic [15:0] bcd;
    logic        pronto;
    logic        ocupado;
    logic [3:0]  anodo;
    logic [6:0]  seg;

    int tests = 0;
    int fails = 0;

    conversor_tempo_bcd #(.DIV_VARREDURA(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .tempo   (tempo),
        .bcd     (bcd),
        .pronto  (pronto),
        .ocupado (ocupado),
        .anodo   (anodo),
        .seg     (seg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected segments for whichever digit is lit, given the current bcd value
    task automatic chk_disp(input string tag, input logic [3:0] an, input logic [6:0] exp_u,
                            input logic [6:0] exp_t, input logic [6:0] exp_h, input logic [6:0] exp_m);
        logic [6:0] e;
        case (an)
            4'b1110: e = exp_u;
            4'b1101: e = exp_t;
            4'b1011: e = exp_h;
            4'b0111: e = exp_m;
            default: e = 7'bxxxxxxx;
        endcase
        chk(tag, 32'(seg), 32'(e));
    endtask

    // Counts negedges until pronto is seen; ocupado counted on the way
    task automatic wait_pronto(input int switch_at, input logic [11:0] novo,
                               output int cyc, output int occ);
        cyc = 0;
        occ = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            cyc++;
            if (switch_at != 0 && cyc == switch_at) tempo = novo;
            if (pronto) break;
            if (ocupado) occ++;
        end
    endtask

    task automatic convert(input string tag, input logic [11:0] val, input logic [15:0] exp);
        int cyc, occ;
        tempo = val;
        wait_pronto(0, 12'd0, cyc, occ);
        chk({tag, "_lat"}, 32'(cyc), 32'd14);
        chk({tag, "_occ"}, 32'(occ), 32'd13);
        chk({tag, "_bcd"}, 32'(bcd), 32'(exp));
        @(negedge clock);
        chk({tag, "_pulse1"}, 32'(pronto), 32'd0);
        chk({tag, "_hold"}, 32'(bcd), 32'(exp));
    endtask

    initial begin
        int cyc, occ, guard;
        logic [3:0] exp_an;
        reset = 1'b0;
        tempo = 12'd0;
        repeat (2) @(negedge clock);
        chk("rst_bcd", 32'(bcd), 32'h0000);
        chk("rst_pronto", 32'(pronto), 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_anodo", 32'(anodo), 32'(4'b1110));
        chk("rst_seg", 32'(seg), 32'(7'b1000000));

        // Idle with tempo = 0: nothing converts, display shows "   0"
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            chk("idle_pronto", 32'(pronto), 32'd0);
            chk("idle_bcd", 32'(bcd), 32'h0000);
            chk_disp("idle_seg", anodo, 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);
        end

        convert("c1230", 12'd1230, 16'h1230);
        convert("c4095", 12'd4095, 16'h4095);
        convert("c10", 12'd10, 16'h0010);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            chk_disp("disp10", anodo, 7'b1000000, 7'b1111001, 7'b1111111, 7'b1111111);
        end

        // tempo changes mid-conversion: first result is the old value
        tempo = 12'd500;
        wait_pronto(5, 12'd700, cyc, occ);
        chk("c500_lat", 32'(cyc), 32'd14);
        chk("c500_bcd", 32'(bcd), 32'h0500);
        wait_pronto(0, 12'd0, cyc, occ);
        chk("c700_lat", 32'(cyc), 32'd14);
        chk("c700_bcd", 32'(bcd), 32'h0700);
        @(negedge clock);
        chk("c700_pulse1", 32'(pronto), 32'd0);

        // Reset during conversion of 999
        tempo = 12'd999;
        repeat (6) @(negedge clock);
        chk("abort_busy", 32'(ocupado), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_bcd", 32'(bcd), 32'h0000);
        chk("abort_ocupado", 32'(ocupado), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("abort_pronto", 32'(pronto), 32'd0);
        end
        reset = 1'b1;
        wait_pronto(0, 12'd0, cyc, occ);
        chk("c999_lat", 32'(cyc), 32'd14);
        chk("c999_occ", 32'(occ), 32'd13);
        chk("c999_bcd", 32'(bcd), 32'h0999);

        // Align on the first units-digit cycle, then check a full scan and wrap
        guard = 0;
        @(negedge clock);
        while (!(anodo == 4'b0111) && guard < 20) begin @(negedge clock); guard++; end
        while (!(anodo == 4'b1110) && guard < 20) begin @(negedge clock); guard++; end
        chk("scan_align", 32'(guard < 20), 32'd1);
        for (int i = 0; i <= 32; i++) begin
            exp_an = ~(4'b0001 << ((i / 4) % 4));
            chk("scan_anodo", 32'(anodo), 32'(exp_an));
            if (i < 32) @(negedge clock);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conversor_tempo_bcd.md
CONVERSOR_TEMPO_BCD -- requirements
Module: conversor_tempo_bcd

Interface
REQ-001 SHALL have parameter DIV_VARREDURA, default 50000, clock cycles each display digit stays lit.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port tempo  input  12  unsigned elapsed time in ms from the period-counter stage (tempocontado).
REQ-005 SHALL have port bcd  output  16  last converted value as 4 BCD digits, [15:12] thousands ... [3:0] units.
REQ-006 SHALL have port pronto  output  1  one-cycle pulse marking a new bcd value.
REQ-007 SHALL have port ocupado  output  1  high while a conversion is in progress.
REQ-008 SHALL have port anodo  output  4  digit select, one-hot, active-low; bit 0 = units.
REQ-009 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low, for the selected digit.

Function
REQ-010 SHALL implement FSM states OCIOSO, DESLOCANDO, CONCLUIDO.
REQ-011 OCIOSO: if tempo != ultimo (internal 12-bit register), SHALL load tempo into the shift register, set ultimo <= tempo, clear the 4-bit iteration counter, and go to DESLOCANDO; otherwise SHALL stay in OCIOSO.
REQ-012 DESLOCANDO: each cycle SHALL add 3 to every BCD nibble >= 5, then shift {bcd_work, bin} left by 1 (double-dabble); after the 12th shift SHALL go to CONCLUIDO.
REQ-013 CONCLUIDO: SHALL copy bcd_work to bcd, assert pronto for exactly one cycle, and return to OCIOSO.
REQ-014 Latency SHALL be fixed: change sampled at edge N -> bcd updated and pronto high from edge N+13; ocupado high in DESLOCANDO and CONCLUIDO only.
REQ-015 tempo changes during DESLOCANDO/CONCLUIDO SHALL be ignored; the value present on return to OCIOSO SHALL be compared against ultimo, so a final settled value is never lost.
REQ-016 bcd SHALL hold its value between conversions; pronto SHALL never be high for two consecutive cycles.
REQ-017 Input range 0..4095 SHALL always fit 4 digits; no overflow flag.
REQ-018 Scan counter SHALL count 0..DIV_VARREDURA-1, then wrap and advance the digit index 0->1->2->3->0.
REQ-019 anodo SHALL drive low only the bit of the current digit index; seg SHALL show that digit of bcd.
REQ-020 Leading zeros SHALL be blanked (seg = all 1s) for thousands, hundreds and tens; units SHALL always be shown (value 0 shows "0").
REQ-021 bcd update and scanning SHALL be independent; a new bcd SHALL appear on the next displayed digit without resetting the scan.

Reset
REQ-022 While reset = 0: state = OCIOSO, ultimo = 0, bcd = 0, shift register and counters = 0, pronto = 0, ocupado = 0, digit index = 0.
REQ-023 Reset assertion mid-conversion SHALL abort the conversion without a pronto pulse; after release, a nonzero tempo SHALL start a fresh conversion.
REQ-024 With tempo = 0 after reset, no conversion SHALL start; display SHALL show "   0" (anodo = 4'b1110 and seg = 7'b1000000 during digit 0).

Structure
REQ-025 Package conversor_tempo_pkg SHALL hold the FSM state enum, the number of iterations (12), and the 7-segment code constants (digits 0-9 and blank).
REQ-026 Sub-module decodificador_7seg SHALL be combinational: 4-bit digit + blank flag -> 7-bit active-low segments; instantiated once, after the digit mux.

Verification (DIV_VARREDURA = 4 in bench)
REQ-027 Release reset, tempo = 0 for 100 cycles -> pronto never high, bcd = 16'h0000, only units digit lit showing 0.
REQ-028 tempo = 1230 held -> pronto pulse exactly 13 cycles after the sampling edge, bcd = 16'h1230, ocupado high 13 cycles.
REQ-029 tempo = 4095 then 10 -> bcd = 16'h4095 then 16'h0010; digits 3 and 2 blanked, tens shows 1, units shows 0.
REQ-030 tempo 500 -> 700 at cycle 5 of the conversion -> first pronto with bcd = 16'h0500, then a second conversion yielding 16'h0700.
REQ-031 reset pulled low at cycle 6 of converting 999 -> no pronto, bcd = 0; after release, conversion of 999 completes with bcd = 16'h0999.
REQ-032 Free-run 32 cycles -> anodo sequence 1110,1101,1011,0111, each held 4 cycles, then wraps to 1110.
